// File: rtl/vga_sram_reader.sv
// Pixel prefetch ahead of the VGA controller: streams an RGB565 frame buffer from SRAM
// through a small FIFO and expands each popped pixel to 10-bit R/G/B.
module vga_sram_reader #(
    parameter int unsigned H_ACT      = 800,
    parameter int unsigned V_ACT      = 600,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iVGA_VS,
    input  logic              iRequest,
    input  logic              iSRAM_Busy,
    input  logic [15:0]       iSRAM_DQ,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic              oSRAM_RD,
    output logic [9:0]        oRed,
    output logic [9:0]        oGreen,
    output logic [9:0]        oBlue,
    output logic              oUnderflow,
    output logic              oReady
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACT * V_ACT - 1);

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} stateT;

    stateT               state;
    stateT               stateNext;
    logic                vsQ;
    logic [ADDR_W-1:0]   addrQ;
    logic [READ_LAT-1:0] validPipe;
    logic [READ_LAT-1:0] pipeNext;
    logic [15:0]         fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [CNT_W-1:0]    fifoCount;
    logic [CNT_W-1:0]    countNext;
    logic [CNT_W-1:0]    inFlight;
    logic [CNT_W:0]      occupancy;
    logic                frameStart;
    logic                issue;
    logic                lastIssue;
    logic                push;
    logic                pop;

    function automatic logic [29:0] expand(input logic [15:0] p);
        return {p[15:11], p[15:11], p[10:5], p[10:7], p[4:0], p[4:0]};
    endfunction

    always_comb begin
        frameStart = vsQ && !iVGA_VS;

        inFlight = '0;
        for (int i = 0; i < int'(READ_LAT); i++) begin
            inFlight = inFlight + CNT_W'(validPipe[i]);
        end
        // Reads already in flight reserve FIFO space, so a push can never overflow.
        occupancy = {1'b0, fifoCount} + {1'b0, inFlight};
        issue     = ((state == StFill) || (state == StRun)) && !iSRAM_Busy &&
                    (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        lastIssue = issue && (addrQ == LAST_ADDR);

        push      = validPipe[READ_LAT-1];
        pop       = iRequest && (fifoCount != '0);
        countNext = fifoCount + CNT_W'(push) - CNT_W'(pop);

        pipeNext    = '0;
        pipeNext[0] = issue;
        for (int i = 1; i < int'(READ_LAT); i++) begin
            pipeNext[i] = validPipe[i-1];
        end

        stateNext = state;
        unique case (state)
            StFill: begin
                if (lastIssue) begin
                    stateNext = StDone;
                end else if (countNext == CNT_W'(FIFO_DEPTH)) begin
                    stateNext = StRun;
                end
            end
            StRun: begin
                if (lastIssue) begin
                    stateNext = StDone;
                end
            end
            default: stateNext = state;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= StIdle;
            vsQ        <= 1'b0;
            addrQ      <= '0;
            validPipe  <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifoCount  <= '0;
            oSRAM_ADDR <= '0;
            oSRAM_RD   <= 1'b0;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            oUnderflow <= 1'b0;
            oReady     <= 1'b0;
        end else begin
            vsQ <= iVGA_VS;
            if (frameStart) begin
                state      <= StFill;
                addrQ      <= '0;
                validPipe  <= '0;
                wrPtr      <= '0;
                rdPtr      <= '0;
                fifoCount  <= '0;
                oSRAM_RD   <= 1'b0;
                oRed       <= '0;
                oGreen     <= '0;
                oBlue      <= '0;
                oUnderflow <= 1'b0;
                oReady     <= 1'b0;
            end else begin
                state     <= stateNext;
                validPipe <= pipeNext;
                fifoCount <= countNext;
                oReady    <= (stateNext == StRun) || (stateNext == StDone);
                if (push) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end

                oSRAM_RD <= issue;
                if (issue) begin
                    oSRAM_ADDR <= addrQ;
                    if (addrQ != LAST_ADDR) begin
                        addrQ <= addrQ + ADDR_W'(1);
                    end
                end

                // No bypass: a request on an empty FIFO underflows even if a push lands now.
                if (pop) begin
                    {oRed, oGreen, oBlue} <= expand(fifoMem[rdPtr]);
                end else begin
                    oRed   <= '0;
                    oGreen <= '0;
                    oBlue  <= '0;
                end
                if (iRequest && !pop) begin
                    oUnderflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST && !frameStart && push) begin
            fifoMem[wrPtr] <= iSRAM_DQ;
        end
    end

endmodule

// File: tb/tb_vga_sram_reader.sv
// Self-checking bench for vga_sram_reader: SRAM model, scoreboard of expected pixels and
// a colour-expansion vector table.
module tb_vga_sram_reader;

    localparam int unsigned H_ACT      = 8;
    localparam int unsigned V_ACT      = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned READ_LAT   = 2;
    localparam int unsigned ADDR_W     = 20;
    localparam int          FRAME      = int'(H_ACT * V_ACT);

    logic              iCLK = 1'b0;
    logic              iRST;
    logic              iVGA_VS;
    logic              iRequest;
    logic              iSRAM_Busy;
    logic [15:0]       iSRAM_DQ;
    logic [ADDR_W-1:0] oSRAM_ADDR;
    logic              oSRAM_RD;
    logic [9:0]        oRed;
    logic [9:0]        oGreen;
    logic [9:0]        oBlue;
    logic              oUnderflow;
    logic              oReady;

    vga_sram_reader #(
        .H_ACT      (H_ACT),
        .V_ACT      (V_ACT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .READ_LAT   (READ_LAT),
        .ADDR_W     (ADDR_W)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iVGA_VS    (iVGA_VS),
        .iRequest   (iRequest),
        .iSRAM_Busy (iSRAM_Busy),
        .iSRAM_DQ   (iSRAM_DQ),
        .oSRAM_ADDR (oSRAM_ADDR),
        .oSRAM_RD   (oSRAM_RD),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oUnderflow (oUnderflow),
        .oReady     (oReady)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [15:0] data;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
    } vecT;

    typedef struct {
        int          readyAt;
        logic [29:0] pix;
    } flightT;

    vecT    tbl [6];
    flightT flight [$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     dataMode = 0;
    int     expAddr = 0;
    int     rdCount = 0;
    int     lastRdAddr = -1;
    bit     rdNow = 0;
    bit     chkEn = 0;
    logic   vsPrev = 1'b0;
    logic   expUf = 1'b0;
    logic [29:0] expOut = '0;

    function automatic logic [15:0] dataFn(input int a);
        if (dataMode == 0) begin
            return a[15:0];
        end
        return tbl[a % 6].data;
    endfunction

    function automatic logic [29:0] expandRef(input logic [15:0] d);
        logic [9:0] r, g, b;
        r = {d[15:11], d[15:11]};
        g = {d[10:5], d[10:7]};
        b = {d[4:0], d[4:0]};
        return {r, g, b};
    endfunction

    // Synchronous SRAM: data for the address seen in cycle t is on the bus in cycle t+1,
    // which the reader captures READ_LAT edges after the issuing edge.
    always @(posedge iCLK) begin
        cyc      <= cyc + 1;
        iSRAM_DQ <= dataFn(int'(oSRAM_ADDR));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare this cycle's outputs, log any issued read, then drive the next inputs.
    task automatic step(input logic rst, input logic req, input logic busy, input logic vs);
        logic fs;
        @(negedge iCLK);
        if (chkEn) begin
            check("pixel", {2'b00, oRed, oGreen, oBlue}, {2'b00, expOut});
            check("underflow", {31'd0, oUnderflow}, {31'd0, expUf});
        end
        rdNow = 1'b0;
        if (oSRAM_RD === 1'b1) begin
            rdNow = 1'b1;
            check("rd_addr", {12'd0, oSRAM_ADDR}, 32'(expAddr));
            flight.push_back('{readyAt: cyc + int'(READ_LAT), pix: expandRef(dataFn(expAddr))});
            lastRdAddr = expAddr;
            expAddr++;
            rdCount++;
        end
        iRST       = rst;
        iRequest   = req;
        iSRAM_Busy = busy;
        iVGA_VS    = vs;
        fs         = vsPrev && !vs;
        vsPrev     = vs;
        if (rst) begin
            flight.delete();
            expAddr = 0;
            rdCount = 0;
            expOut  = '0;
            expUf   = 1'b0;
            vsPrev  = 1'b0;
            chkEn   = 1'b1;
        end else if (fs) begin
            flight.delete();
            expAddr = 0;
            rdCount = 0;
            expOut  = '0;
            expUf   = 1'b0;
        end else if (req) begin
            if (flight.size() > 0 && flight[0].readyAt <= cyc) begin
                expOut = flight.pop_front().pix;
            end else begin
                expOut = '0;
                expUf  = 1'b1;
            end
        end else begin
            expOut = '0;
        end
    endtask

    task automatic frameStart();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic waitReady();
        int k = 0;
        while (oReady !== 1'b1 && k < 30) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            k++;
        end
        check("ready_wait", {31'd0, oReady}, 32'd1);
    endtask

    initial begin
        tbl[0] = '{16'hF800, 10'h3FF, 10'h000, 10'h000};
        tbl[1] = '{16'h07E0, 10'h000, 10'h3FF, 10'h000};
        tbl[2] = '{16'h001F, 10'h000, 10'h000, 10'h3FF};
        tbl[3] = '{16'hFFFF, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[4] = '{16'h8410, 10'h210, 10'h208, 10'h210};
        tbl[5] = '{16'h0000, 10'h000, 10'h000, 10'h000};
        iRST = 1'b1; iRequest = 1'b0; iSRAM_Busy = 1'b0; iVGA_VS = 1'b1;

        // Reset state, then frame start and the initial fill.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_ready", {31'd0, oReady}, 32'd0);
        check("rst_rd", {31'd0, oSRAM_RD}, 32'd0);
        check("rst_addr", {12'd0, oSRAM_ADDR}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("fill_rd", {31'd0, oSRAM_RD}, (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            check("fill_ready", {31'd0, oReady}, (k >= 7) ? 32'd1 : 32'd0);
        end

        // Full frame stream.
        for (int k = 0; k < FRAME; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("frame_reads", 32'(rdCount), 32'(FRAME));
        check("last_addr", 32'(lastRdAddr), 32'(FRAME - 1));
        check("done_ready", {31'd0, oReady}, 32'd1);
        check("done_no_rd", {31'd0, oSRAM_RD}, 32'd0);
        check("frame_uflow", {31'd0, oUnderflow}, 32'd0);

        // Bus busy while streaming drains the FIFO into underflow.
        frameStart();
        waitReady();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("busy_uflow_set", {31'd0, oUnderflow}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("busy_uflow_sticky", {31'd0, oUnderflow}, 32'd1);
        frameStart();
        check("fs_uflow_clear", {31'd0, oUnderflow}, 32'd0);

        // Colour expansion vectors, pixel i carries tbl[i % 6].
        dataMode = 1;
        frameStart();
        waitReady();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, (i < FRAME - 1) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            check("vec_r", {22'd0, oRed}, {22'd0, tbl[i % 6].r});
            check("vec_g", {22'd0, oGreen}, {22'd0, tbl[i % 6].g});
            check("vec_b", {22'd0, oBlue}, {22'd0, tbl[i % 6].b});
        end
        dataMode = 0;

        // Frame start mid-frame with reads in flight.
        frameStart();
        waitReady();
        begin
            int k = 0;
            while (!(rdNow && lastRdAddr == 9) && k < 30) begin
                step(1'b0, 1'b1, 1'b0, 1'b1);
                k++;
            end
            check("reach_addr9", 32'(lastRdAddr), 32'd9);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("fs_no_issue", {31'd0, oSRAM_RD}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("fs_empty_pix", {2'b00, oRed, oGreen, oBlue}, 32'd0);
        check("fs_empty_uflow", {31'd0, oUnderflow}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        waitReady();
        check("refill_last", 32'(lastRdAddr), 32'd3);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Reset pulse mid-stream.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_pix", {2'b00, oRed, oGreen, oBlue}, 32'd0);
        check("mid_rst_ready", {31'd0, oReady}, 32'd0);
        check("mid_rst_addr", {12'd0, oSRAM_ADDR}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("idle_no_rd", {31'd0, oSRAM_RD}, 32'd0);
        end
        check("idle_ready", {31'd0, oReady}, 32'd0);
        frameStart();
        waitReady();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
